// File: rtl/inst_encoder_loader_if.sv
// Field-bundle input stream and imem write port of the instruction encoder/loader.
// master = boot/test path (drives fields, sinks writes); slave = encoder.
interface inst_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs RV32I field bundles into instruction words and writes them to sequential imem
// word addresses through a one-entry output buffer, with count/full/err tracking.
module inst_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                addr_clr,
  inst_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  logic              weQ, weD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [31:0]       wdataQ, wdataD;
  logic [ADDR_W:0]   countQ, countD;
  logic              fullQ, fullD;
  logic              errQ, errD;

  logic [6:0]  opcode;
  logic [31:0] word;
  logic        legal;
  logic        misaligned;
  logic        inReady;
  logic        accept;
  logic        complete;

  // Field encoder
  always_comb begin
    opcode     = 7'b0000000;
    word       = 32'h0;
    legal      = 1'b1;
    misaligned = 1'b0;
    case (bus.in_kind)
      4'd0: begin
        opcode = 7'b0110011;
        word   = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
      end
      4'd1: begin
        opcode = 7'b0010011;
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
          word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
        end else begin
          word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
        end
      end
      4'd2: begin
        opcode     = 7'b1100011;
        misaligned = bus.in_imm[0];
        word       = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      bus.in_imm[4:1], bus.in_imm[11], opcode};
      end
      4'd3: begin
        opcode = 7'b1100111;
        word   = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, opcode};
      end
      4'd4: begin
        opcode     = 7'b1101111;
        misaligned = bus.in_imm[0];
        word       = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                      bus.in_rd, opcode};
      end
      4'd5: begin
        opcode = 7'b0010111;
        word   = {bus.in_imm[31:12], bus.in_rd, opcode};
      end
      4'd6: begin
        opcode = 7'b0110111;
        word   = {bus.in_imm[31:12], bus.in_rd, opcode};
      end
      4'd7: begin
        opcode = 7'b0000011;
        word   = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
      end
      4'd8: begin
        opcode = 7'b0100011;
        word   = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0],
                  opcode};
      end
      4'd9: begin
        opcode = 7'b1110011;
        word   = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
      end
      default: legal = 1'b0;
    endcase
  end

  // A bundle taken while the last address drains would have to wrap, so hold it off.
  assign inReady  = rst_n && !fullQ && !addr_clr &&
                    (!weQ || (bus.mem_ready && addrQ != LastAddr));
  assign accept   = bus.in_valid && inReady;
  assign complete = weQ && bus.mem_ready;

  always_comb begin
    weD    = weQ;
    addrD  = addrQ;
    wdataD = wdataQ;
    countD = countQ;
    fullD  = fullQ;
    errD   = errQ;
    if (addr_clr) begin
      weD    = 1'b0;
      addrD  = BaseAddr;
      countD = '0;
      fullD  = 1'b0;
      errD   = 1'b0;
    end else begin
      if (complete) begin
        weD    = 1'b0;
        addrD  = addrQ + 1'b1;
        countD = countQ + 1'b1;
        if (addrQ == LastAddr) fullD = 1'b1;
      end
      if (accept) begin
        if (legal) begin
          weD    = 1'b1;
          wdataD = word;
        end
        if (!legal || misaligned) errD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weQ    <= 1'b0;
      addrQ  <= BaseAddr;
      wdataQ <= 32'h0;
      countQ <= '0;
      fullQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      weQ    <= weD;
      addrQ  <= addrD;
      wdataQ <= wdataD;
      countQ <= countD;
      fullQ  <= fullD;
      errQ   <= errD;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.mem_we    = weQ;
  assign bus.mem_addr  = addrQ;
  assign bus.mem_wdata = wdataQ;
  assign count         = countQ;
  assign full          = fullQ;
  assign err           = errQ;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: encoding table, stall, full/clear, error and reset cases.
module tb_inst_encoder_loader;

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  localparam int NVec = 13;

  logic       clk;
  logic       rst_n;
  logic       addr_clr;
  logic       addr_clr2;
  logic [8:0] count;
  logic       full;
  logic       err;
  logic [2:0] count2;
  logic       full2;
  logic       err2;

  int tests = 0;
  int fails = 0;

  vec_t vecs[NVec];

  inst_encoder_loader_if #(.ADDR_W(8)) bus ();
  inst_encoder_loader_if #(.ADDR_W(2)) bus2 ();

  inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_clr(addr_clr),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .err     (err)
  );

  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_clr(addr_clr2),
    .bus     (bus2),
    .count   (count2),
    .full    (full2),
    .err     (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid  = valid;
    bus.in_kind   = v.kind;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
  endtask

  task automatic drive2(input vec_t v, input logic valid);
    bus2.in_valid  = valid;
    bus2.in_kind   = v.kind;
    bus2.in_rd     = v.rd;
    bus2.in_rs1    = v.rs1;
    bus2.in_rs2    = v.rs2;
    bus2.in_funct3 = v.f3;
    bus2.in_funct7 = v.f7;
    bus2.in_imm    = v.imm;
  endtask

  initial begin
    vec_t tmp;
    int   k;
    int   nw;

    //             kind   rd     rs1    rs2    f3    f7       imm           word
    vecs[0]  = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093}; // addi
    vecs[1]  = '{4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h002081B3}; // add
    vecs[2]  = '{4'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8,        32'h00208463}; // beq +8
    vecs[3]  = '{4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16,       32'h010000EF}; // jal +16
    vecs[4]  = '{4'd1, 5'd5, 5'd5, 5'd0, 3'd5, 7'h20, 32'd3,        32'h4032D293}; // srai
    vecs[5]  = '{4'd6, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123453B7}; // lui
    vecs[6]  = '{4'd5, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDEFFF, 32'hABCDE117}; // auipc
    vecs[7]  = '{4'd8, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd12,       32'h0020A623}; // sw
    vecs[8]  = '{4'd7, 5'd4, 5'd3, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFC, 32'hFFC1A203}; // lw -4
    vecs[9]  = '{4'd3, 5'd1, 5'd5, 5'd0, 3'd7, 7'h00, 32'd0,        32'h000280E7}; // jalr
    vecs[10] = '{4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h00000073}; // ecall
    vecs[11] = '{4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0,        32'h403100B3}; // sub
    vecs[12] = '{4'd2, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFFFFFC, 32'hFE209EE3}; // bne -4

    rst_n          = 1'b0;
    addr_clr       = 1'b0;
    addr_clr2      = 1'b0;
    bus.mem_ready  = 1'b1;
    bus2.mem_ready = 1'b1;
    drive(vecs[0], 1'b1);
    drive2(vecs[0], 1'b0);

    #2;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'h0);
    check("reset count", 32'(count), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);

    #20 rst_n = 1'b1;
    drive(vecs[0], 1'b0);
    tick();

    // Encoding table, back-to-back with mem_ready high
    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i], 1'b1);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      check($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'd1);
      check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].word);
      check($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(i));
      check($sformatf("v%0d count", i), 32'(count), 32'(i));
      check($sformatf("v%0d err", i), 32'(err), 32'd0);
    end
    bus.in_valid = 1'b0;
    tick();
    check("table count", 32'(count), 32'd13);
    check("table mem_we idle", 32'(bus.mem_we), 32'd0);

    // Stall: word held stable while mem_ready is low
    bus.mem_ready = 1'b0;
    drive(vecs[0], 1'b1);
    #1;
    check("stall first accept", 32'(bus.in_ready), 32'd1);
    tick();
    drive(vecs[1], 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("stall%0d mem_we", c), 32'(bus.mem_we), 32'd1);
      check($sformatf("stall%0d mem_addr", c), 32'(bus.mem_addr), 32'd13);
      check($sformatf("stall%0d mem_wdata", c), bus.mem_wdata, 32'h00500093);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("stall release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("stall next addr", 32'(bus.mem_addr), 32'd14);
    check("stall next wdata", bus.mem_wdata, 32'h002081B3);
    check("stall count", 32'(count), 32'd14);
    tick();
    check("stall final count", 32'(count), 32'd15);
    check("stall final mem_we", 32'(bus.mem_we), 32'd0);

    // Illegal kind: accepted, no write, sticky err
    tmp      = vecs[0];
    tmp.kind = 4'd12;
    drive(tmp, 1'b1);
    #1;
    check("illegal in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("illegal mem_we", 32'(bus.mem_we), 32'd0);
    check("illegal err", 32'(err), 32'd1);
    check("illegal count", 32'(count), 32'd15);
    check("illegal addr", 32'(bus.mem_addr), 32'd15);

    // Misaligned branch: bit 0 dropped, still written; left pending for the clear
    tmp     = vecs[2];
    tmp.imm = 32'd9;
    drive(tmp, 1'b1);
    bus.mem_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("misalign mem_we", 32'(bus.mem_we), 32'd1);
    check("misalign addr", 32'(bus.mem_addr), 32'd15);
    check("misalign wdata", bus.mem_wdata, 32'h00208463);
    check("misalign err", 32'(err), 32'd1);

    addr_clr = 1'b1;
    drive(vecs[0], 1'b1);
    #1;
    check("clr in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    addr_clr     = 1'b0;
    bus.in_valid = 1'b0;
    check("clr mem_we", 32'(bus.mem_we), 32'd0);
    check("clr err", 32'(err), 32'd0);
    check("clr count", 32'(count), 32'd0);
    check("clr full", 32'(full), 32'd0);
    bus.mem_ready = 1'b1;
    drive(vecs[0], 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("post-clr mem_we", 32'(bus.mem_we), 32'd1);
    check("post-clr addr", 32'(bus.mem_addr), 32'd0);
    tick();
    check("post-clr count", 32'(count), 32'd1);

    // ADDR_W=2: four writes, then full and the fifth bundle refused
    k  = 0;
    nw = 0;
    for (int c = 0; c < 7; c++) begin
      drive2(vecs[k % 5], k < 5);
      #1;
      check($sformatf("d2 c%0d in_ready", c), 32'(bus2.in_ready), 32'(c < 4));
      if (bus2.in_ready && bus2.in_valid) k++;
      tick();
      if (bus2.mem_we) begin
        check($sformatf("d2 w%0d addr", nw), 32'(bus2.mem_addr), 32'(nw));
        check($sformatf("d2 w%0d wdata", nw), bus2.mem_wdata, vecs[nw % 5].word);
        nw++;
      end
    end
    check("d2 accepted", 32'(k), 32'd4);
    check("d2 writes", 32'(nw), 32'd4);
    check("d2 full", 32'(full2), 32'd1);
    check("d2 count", 32'(count2), 32'd4);
    bus2.in_valid = 1'b0;
    addr_clr2     = 1'b1;
    tick();
    addr_clr2 = 1'b0;
    check("d2 clr full", 32'(full2), 32'd0);
    check("d2 clr count", 32'(count2), 32'd0);
    drive2(vecs[3], 1'b1);
    tick();
    bus2.in_valid = 1'b0;
    check("d2 post-clr addr", 32'(bus2.mem_addr), 32'd0);
    check("d2 post-clr wdata", bus2.mem_wdata, 32'h010000EF);

    // Asynchronous reset with a stalled write pending
    bus.mem_ready = 1'b0;
    drive(vecs[1], 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("prereset mem_we", 32'(bus.mem_we), 32'd1);
    check("prereset addr", 32'(bus.mem_addr), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async rst mem_we", 32'(bus.mem_we), 32'd0);
    check("async rst count", 32'(count), 32'd0);
    check("async rst in_ready", 32'(bus.in_ready), 32'd0);
    #10 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    drive(vecs[2], 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("post-rst mem_we", 32'(bus.mem_we), 32'd1);
    check("post-rst addr", 32'(bus.mem_addr), 32'd0);
    check("post-rst wdata", bus.mem_wdata, 32'h00208463);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
